morse_match_engine: RTL

//  Parametrised record/challenge engine for the Morse game. Times a single key into
//  dot/dash symbols, packs them into words, stores P1's words in internal RAM,

---
 rtl/morse_match_engine_pkg.sv | 21 ++
 rtl/morse_match_engine_if.sv | 38 +++
 rtl/morse_match_engine_symbolizer.sv | 53 +++++
 rtl/morse_match_engine.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/morse_match_engine_pkg.sv
// Shared definitions for the Morse record/challenge engine: phase codes,
// symbol codes and the hold-time-to-symbol mapping.
package morse_match_engine_pkg;

  typedef logic [1:0] sym_code_t;

  localparam logic [1:0] ST_START  = 2'd0;
  localparam logic [1:0] ST_REC    = 2'd1;
  localparam logic [1:0] ST_CHAL   = 2'd2;
  localparam logic [1:0] ST_RESULT = 2'd3;

  // Empty slots are 00, so a word with any non-zero pair holds a symbol.
  localparam sym_code_t SYM_EMPTY = 2'b00;
  localparam sym_code_t SYM_DOT   = 2'b01;
  localparam sym_code_t SYM_DASH  = 2'b11;

  function automatic sym_code_t sym_for_hold(input logic reached_dash);
    return reached_dash ? SYM_DASH : SYM_DOT;
  endfunction

endpackage

// File: rtl/morse_match_engine_if.sv
// Control inputs and status outputs of the Morse engine, grouped for the
// player-side driver (master) and the engine itself (slave).
interface morse_match_engine_if #(
  parameter int WORD_W = 10,
  parameter int ADDR_W = 5
);

  // Every control input is a single-cycle pulse or a level with no
  // backpressure: the engine samples it on each clock and never stalls the
  // driver; result pulses (word_ok/word_bad/sym_ovf) are likewise one cycle.
  logic              tick;
  logic              key_pressed;
  logic              next_word;
  logic              done;

  logic [1:0]        state;
  logic [WORD_W-1:0] cur_word;
  logic [ADDR_W-1:0] wr_count;
  logic [ADDR_W-1:0] rd_addr;
  logic [3:0]        tries_left;
  logic              word_ok;
  logic              word_bad;
  logic              win;
  logic              sym_ovf;

  modport master (
    output tick, key_pressed, next_word, done,
    input  state, cur_word, wr_count, rd_addr, tries_left,
    input  word_ok, word_bad, win, sym_ovf
  );

  modport slave (
    input  tick, key_pressed, next_word, done,
    output state, cur_word, wr_count, rd_addr, tries_left,
    output word_ok, word_bad, win, sym_ovf
  );

endinterface

// File: rtl/morse_match_engine_symbolizer.sv
// Times one held key in tick units and emits a DOT or DASH code on release.
module morse_match_engine_symbolizer
  import morse_match_engine_pkg::*;
#(
  parameter int DASH_TICKS = 2
) (
  input  logic      clock,
  input  logic      resetn,
  input  logic      tick,
  input  logic      key_pressed,
  output logic      sym_valid,
  output sym_code_t sym_code
);

  localparam int CNT_W = (DASH_TICKS < 1) ? 1 : $clog2(DASH_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DASH_TICKS);

  logic             key_q;
  logic             armed;
  logic [CNT_W-1:0] hold_cnt;
  logic             key_rise;
  logic             key_fall;

  assign key_rise = key_pressed & ~key_q;
  assign key_fall = ~key_pressed & key_q;

  // key_q resets high so a key still held across reset never looks like a
  // fresh press; armed stays low, so its release emits nothing.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      key_q     <= 1'b1;
      armed     <= 1'b0;
      hold_cnt  <= '0;
      sym_valid <= 1'b0;
      sym_code  <= SYM_EMPTY;
    end else begin
      key_q     <= key_pressed;
      sym_valid <= 1'b0;
      if (key_rise) begin
        armed    <= 1'b1;
        hold_cnt <= '0;
      end else if (armed && key_pressed && tick && hold_cnt != CNT_MAX) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
      if (key_fall && armed) begin
        armed     <= 1'b0;
        sym_valid <= 1'b1;
        sym_code  <= sym_for_hold(hold_cnt == CNT_MAX);
      end
    end
  end

endmodule

// File: rtl/morse_match_engine.sv
// Morse game engine: packs keyed symbols into words, records P1's words in
// an internal RAM, then checks P2's words in order with a per-word retry budget.
module morse_match_engine
  import morse_match_engine_pkg::*;
#(
  parameter  int SYMS       = 5,
  parameter  int DEPTH      = 16,
  parameter  int DASH_TICKS = 2,
  parameter  int MAX_TRIES  = 3,
  localparam int WORD_W     = 2 * SYMS,
  localparam int ADDR_W     = $clog2(DEPTH + 1)
) (
  input logic                 clock,
  input logic                 resetn,
  morse_match_engine_if.slave bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [1:0]        state_q;
  logic [WORD_W-1:0] cur_word_q;
  logic [ADDR_W-1:0] wr_count_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [3:0]        tries_q;
  logic              word_ok_q;
  logic              word_bad_q;
  logic              win_q;
  logic              sym_ovf_q;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] rd_data;

  logic              sym_valid;
  sym_code_t         sym_code;

  logic              nw;
  logic              dn;
  logic              word_nz;
  logic              word_full;
  logic              ram_full;
  logic              accepts_sym;
  logic              commit;
  logic [ADDR_W-1:0] rd_next;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;

  morse_match_engine_symbolizer #(
    .DASH_TICKS (DASH_TICKS)
  ) u_symbolizer (
    .clock       (clock),
    .resetn      (resetn),
    .tick        (bus.tick),
    .key_pressed (bus.key_pressed),
    .sym_valid   (sym_valid),
    .sym_code    (sym_code)
  );

  // Controls are ignored while the key is down; next_word wins over done.
  assign nw          = bus.next_word & ~bus.key_pressed;
  assign dn          = bus.done & ~bus.key_pressed & ~bus.next_word;
  assign word_nz     = |cur_word_q;
  assign word_full   = cur_word_q[WORD_W-1 -: 2] != SYM_EMPTY;
  assign ram_full    = wr_count_q == ADDR_W'(DEPTH);
  assign accepts_sym = state_q != ST_RESULT;
  assign commit      = (state_q == ST_REC) && (nw || dn) && word_nz && !ram_full;
  assign rd_next     = rd_addr_q + ADDR_W'(1);
  assign wr_idx      = wr_count_q[IDX_W-1:0];
  assign rd_idx      = rd_addr_q[IDX_W-1:0];

  // Storage is deliberately not reset; the read is registered off rd_addr so
  // the expected word is already waiting when P2 pulses next_word.
  always_ff @(posedge clock) begin
    if (commit) begin
      mem[wr_idx] <= cur_word_q;
    end
    rd_data <= mem[rd_idx];
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_START;
      cur_word_q <= '0;
      wr_count_q <= '0;
      rd_addr_q  <= '0;
      tries_q    <= 4'(MAX_TRIES);
      word_ok_q  <= 1'b0;
      word_bad_q <= 1'b0;
      win_q      <= 1'b0;
      sym_ovf_q  <= 1'b0;
    end else begin
      word_ok_q  <= 1'b0;
      word_bad_q <= 1'b0;
      sym_ovf_q  <= 1'b0;

      if (accepts_sym && sym_valid) begin
        if (word_full) begin
          sym_ovf_q <= 1'b1;
        end else begin
          cur_word_q <= (cur_word_q << 2) | WORD_W'(sym_code);
        end
      end

      case (state_q)
        ST_START: begin
          if (dn) begin
            state_q    <= ST_REC;
            cur_word_q <= '0;
            wr_count_q <= '0;
            rd_addr_q  <= '0;
            win_q      <= 1'b0;
          end
        end

        ST_REC: begin
          if (nw || dn) begin
            cur_word_q <= '0;
            if (commit) begin
              wr_count_q <= wr_count_q + ADDR_W'(1);
            end
          end
          if (dn && (wr_count_q != '0 || commit)) begin
            state_q   <= ST_CHAL;
            rd_addr_q <= '0;
            tries_q   <= 4'(MAX_TRIES);
          end
        end

        ST_CHAL: begin
          if (nw) begin
            cur_word_q <= '0;
            if (cur_word_q == rd_data) begin
              word_ok_q <= 1'b1;
              rd_addr_q <= rd_next;
              tries_q   <= 4'(MAX_TRIES);
              if (rd_next == wr_count_q) begin
                win_q   <= 1'b1;
                state_q <= ST_RESULT;
              end
            end else begin
              word_bad_q <= 1'b1;
              if (MAX_TRIES != 0) begin
                tries_q <= tries_q - 4'd1;
                if (tries_q == 4'd1) begin
                  win_q   <= 1'b0;
                  state_q <= ST_RESULT;
                end
              end
            end
          end else if (dn) begin
            win_q   <= 1'b0;
            state_q <= ST_RESULT;
          end
        end

        ST_RESULT: begin
          if (dn) begin
            state_q <= ST_START;
          end
        end

        default: state_q <= ST_START;
      endcase
    end
  end

  assign bus.state      = state_q;
  assign bus.cur_word   = cur_word_q;
  assign bus.wr_count   = wr_count_q;
  assign bus.rd_addr    = rd_addr_q;
  assign bus.tries_left = tries_q;
  assign bus.word_ok    = word_ok_q;
  assign bus.word_bad   = word_bad_q;
  assign bus.win        = win_q;
  assign bus.sym_ovf    = sym_ovf_q;

endmodule
